// File: rtl/rv32_decode_stage.sv
// RV32IM decode stage: field split, immediate rebuild, unit classification and
// illegal-encoding detection, with a registered output and a 2-entry skid buffer.
module rv32_decode_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [2:0]      out_class,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic            out_alt,
    output logic [XLEN-1:0] out_imm,
    output logic            out_we
);

    typedef enum logic [2:0] {
        CLS_ALU_R   = 3'd0,
        CLS_ALU_I   = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_MULDIV  = 3'd4,
        CLS_JAL     = 3'd5,
        CLS_ILLEGAL = 3'd7
    } class_e;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        class_e          cls;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic            alt;
        logic [XLEN-1:0] imm;
        logic            we;
    } bundle_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_j;
    bundle_t         dec;
    bundle_t         main_q;
    bundle_t         skid_q;
    logic            main_valid;
    logic            skid_valid;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_j  = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};

    // Decode the incoming word; anything outside the legal set stays ILLEGAL with raw fields.
    always_comb begin
        dec        = '0;
        dec.pc     = in_pc;
        dec.cls    = CLS_ILLEGAL;
        dec.rd     = in_instr[11:7];
        dec.rs1    = in_instr[19:15];
        dec.rs2    = in_instr[24:20];
        dec.funct3 = f3;
        case (opcode)
            OPC_OP: begin
                if (f7 == 7'b0000000) begin
                    dec.cls = CLS_ALU_R;
                end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
                    dec.cls = CLS_ALU_R;
                    dec.alt = 1'b1;
                end else if (f7 == 7'b0000001) begin
                    dec.cls = CLS_MULDIV;
                end
            end
            OPC_OP_IMM: begin
                if ((f3 == 3'b001 && f7 == 7'b0000000) ||
                    (f3 == 3'b101 && (f7 == 7'b0000000 || f7 == 7'b0100000)) ||
                    (f3 != 3'b001 && f3 != 3'b101)) begin
                    dec.cls = CLS_ALU_I;
                    dec.rs2 = '0;
                    dec.imm = imm_i;
                    dec.alt = (f3 == 3'b101) && in_instr[30];
                end
            end
            OPC_LOAD: begin
                if (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
                    dec.cls = CLS_LOAD;
                    dec.rs2 = '0;
                    dec.imm = imm_i;
                end
            end
            OPC_STORE: begin
                if (f3 inside {3'b000, 3'b001, 3'b010}) begin
                    dec.cls = CLS_STORE;
                    dec.rd  = '0;
                    dec.imm = imm_s;
                end
            end
            OPC_JAL: begin
                dec.cls = CLS_JAL;
                dec.rs1 = '0;
                dec.rs2 = '0;
                dec.imm = imm_j;
            end
            default: ;
        endcase
        dec.we = (dec.cls inside {CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_MULDIV, CLS_JAL})
                 && (dec.rd != 5'd0);
    end

    // Output register plus skid slot; the skid always refills main first so order is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || out_ready) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (in_valid) begin
                main_q     <= dec;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (in_valid && !skid_valid) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign in_ready   = !skid_valid;
    assign out_valid  = main_valid;
    assign out_pc     = main_q.pc;
    assign out_class  = main_q.cls;
    assign out_rd     = main_q.rd;
    assign out_rs1    = main_q.rs1;
    assign out_rs2    = main_q.rs2;
    assign out_funct3 = main_q.funct3;
    assign out_alt    = main_q.alt;
    assign out_imm    = main_q.imm;
    assign out_we     = main_q.we;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Self-checking bench for rv32_decode_stage: directed cases plus randomized traffic
// against an occupancy/queue reference model.
module tb_rv32_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [2:0]  out_class;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic        out_alt;
    logic [31:0] out_imm;
    logic        out_we;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  cls;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        alt;
        logic [31:0] imm;
        logic        we;
    } exp_t;

    exp_t q[$];

    rv32_decode_stage #(.XLEN(32), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_class(out_class), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_alt(out_alt), .out_imm(out_imm), .out_we(out_we)
    );

    always #5 clk = ~clk;

    // Reference decode built from the instruction-set rules with plain arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        int   op, f3, f7;
        int   jv;
        op = int'(ins[6:0]);
        f3 = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        e.pc  = pc;
        e.cls = 3'd7;
        e.rd  = ins[11:7];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.f3  = ins[14:12];
        e.alt = 1'b0;
        e.imm = 32'd0;
        if (op == 'h33) begin
            if (f7 == 0) e.cls = 3'd0;
            else if (f7 == 'h20 && (f3 == 0 || f3 == 5)) begin e.cls = 3'd0; e.alt = 1'b1; end
            else if (f7 == 1) e.cls = 3'd4;
        end else if (op == 'h13) begin
            if ((f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 'h20) : 1'b1) begin
                e.cls = 3'd1; e.rs2 = 5'd0;
                e.imm = 32'($signed(ins) >>> 20);
                e.alt = (f3 == 5 && f7 == 'h20);
            end
        end else if (op == 'h03) begin
            if (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) begin
                e.cls = 3'd2; e.rs2 = 5'd0;
                e.imm = 32'($signed(ins) >>> 20);
            end
        end else if (op == 'h23) begin
            if (f3 <= 2) begin
                e.cls = 3'd3; e.rd = 5'd0;
                e.imm = 32'(($signed(ins) >>> 25) * 32 + int'(ins[11:7]));
            end
        end else if (op == 'h6F) begin
            e.cls = 3'd5; e.rs1 = 5'd0; e.rs2 = 5'd0;
            jv = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            if (ins[31]) jv = jv - (1 << 20);
            e.imm = 32'(jv);
        end
        e.we = (e.cls != 3'd3 && e.cls != 3'd7) && (e.rd != 5'd0);
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
        n_tests++; if ({out_pc, out_class, out_rd, out_rs1, out_rs2, out_funct3, out_alt, out_imm, out_we} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got pc=%h cls=%0d imm=%h we=%b exp all zero", out_pc, out_class, out_imm, out_we);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h00500A13; in_pc = 32'h0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_early: out_valid got %b exp 0", out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_latency: out_valid got %b exp 1", out_valid); end
        n_tests++; if (out_class !== 3'd1 || out_rd !== 5'd20 || out_rs1 !== 5'd0 || out_imm !== 32'd5 || out_we !== 1'b1) begin
            n_fail++; $display("FAIL addi_fields: got cls=%0d rd=%0d rs1=%0d imm=%h we=%b exp 1/20/0/5/1", out_class, out_rd, out_rs1, out_imm, out_we);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_jal();
        in_valid = 1'b1; in_instr = 32'h002000EF; in_pc = 32'h100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || out_class !== 3'd5 || out_rd !== 5'd1 || out_imm !== 32'd2 || out_pc !== 32'h100 || out_we !== 1'b1) begin
            n_fail++; $display("FAIL jal: got v=%b cls=%0d rd=%0d imm=%h pc=%h we=%b exp 1/5/1/2/100/1", out_valid, out_class, out_rd, out_imm, out_pc, out_we);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sw();
        in_valid = 1'b1; in_instr = 32'hFE202E23; in_pc = 32'h104;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_tests++; if (out_class !== 3'd3 || out_rs2 !== 5'd2 || out_imm !== 32'hFFFFFFFC || out_we !== 1'b0 || out_rd !== 5'd0) begin
            n_fail++; $display("FAIL sw: got cls=%0d rs2=%0d imm=%h we=%b rd=%0d exp 3/2/fffffffc/0/0", out_class, out_rs2, out_imm, out_we, out_rd);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_instr = 32'h022080B3; in_pc = 32'h108;
        @(posedge clk); #1;
        in_instr = 32'h00000000; in_pc = 32'h10C;
        n_tests++; if (out_valid !== 1'b1 || out_class !== 3'd4 || out_rd !== 5'd1 || out_we !== 1'b1) begin
            n_fail++; $display("FAIL mul: got v=%b cls=%0d rd=%0d we=%b exp 1/4/1/1", out_valid, out_class, out_rd, out_we);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || out_class !== 3'd7 || out_we !== 1'b0 || out_imm !== 32'd0 || out_pc !== 32'h10C) begin
            n_fail++; $display("FAIL zero_word: got v=%b cls=%0d we=%b imm=%h pc=%h exp 1/7/0/0/10c", out_valid, out_class, out_we, out_imm, out_pc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        logic [31:0] got[$];
        logic        acc;
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h200;
        @(posedge clk); #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready1: got %b exp 1", in_ready); end
        in_instr = 32'h00200113; in_pc = 32'h204;
        @(posedge clk); #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready2: got %b exp 0", in_ready); end
        in_instr = 32'h00300193; in_pc = 32'h208;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h200 || out_rd !== 5'd1) begin
            n_fail++; $display("FAIL stall_hold: got rdy=%b v=%b pc=%h rd=%0d exp 0/1/200/1", in_ready, out_valid, out_pc, out_rd);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) got.push_back(out_pc);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        n_tests++; if (got.size() != 3) begin n_fail++; $display("FAIL stall_count: got %0d exp 3", got.size()); end
        for (int k = 0; k < 3 && k < got.size(); k++) begin
            n_tests++; if (got[k] !== 32'h200 + 32'(4 * k)) begin n_fail++; $display("FAIL stall_order%0d: got %h exp %h", k, got[k], 32'h200 + 32'(4 * k)); end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h300;
        @(posedge clk); #1;
        in_pc = 32'h304;
        @(posedge clk); #1;
        in_pc = 32'h308; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_full: got v=%b rdy=%b exp 0/1", out_valid, in_ready);
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after%0d: out_valid got %b exp 0", c, out_valid); end
        end
        // one slot full, word offered with in_ready high during flush is dropped
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h310;
        @(posedge clk); #1;
        in_pc = 32'h314; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop: out_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_rst_mid_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFE202E23; in_pc = 32'h400;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'h0 || out_class !== 3'd0 || out_imm !== 32'd0) begin
            n_fail++; $display("FAIL rst_mid_stall: got v=%b rdy=%b pc=%h cls=%0d imm=%h exp 0/1/0/0/0", out_valid, in_ready, out_pc, out_class, out_imm);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [6:0]  ops[6];
        logic [6:0]  f7s[4];
        logic [31:0] r;
        logic        acc, drn;
        exp_t        e;
        ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23; ops[4] = 7'h6F; ops[5] = 7'h00;
        f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01; f7s[3] = 7'h00;
        q.delete();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom;
            if ($urandom_range(0, 7) != 0) begin
                r[6:0] = ops[$urandom_range(0, 4)];
                if ($urandom_range(0, 3) != 0) r[31:25] = f7s[$urandom_range(0, 3)];
            end
            in_instr  = r;
            in_pc     = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            @(negedge clk);
            n_tests++; if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                n_fail++; $display("FAIL rand_hs%0d: got v=%b rdy=%b exp occupancy %0d", i, out_valid, in_ready, q.size());
            end
            if (q.size() > 0) begin
                e = q[0];
                n_tests++;
                if ({out_pc, out_class, out_rd, out_rs1, out_rs2, out_funct3, out_alt, out_imm, out_we} !==
                    {e.pc, e.cls, e.rd, e.rs1, e.rs2, e.f3, e.alt, e.imm, e.we}) begin
                    n_fail++;
                    $display("FAIL rand_bundle%0d: got pc=%h cls=%0d rd=%0d rs1=%0d rs2=%0d f3=%0d alt=%b imm=%h we=%b exp pc=%h cls=%0d rd=%0d rs1=%0d rs2=%0d f3=%0d alt=%b imm=%h we=%b",
                        i, out_pc, out_class, out_rd, out_rs1, out_rs2, out_funct3, out_alt, out_imm, out_we,
                        e.pc, e.cls, e.rd, e.rs1, e.rs2, e.f3, e.alt, e.imm, e.we);
                end
            end
            acc = in_valid && (q.size() < 2);
            drn = out_ready && (q.size() > 0);
            e = ref_decode(in_instr, in_pc);
            @(posedge clk);
            if (flush) q.delete();
            else begin
                if (drn) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
            #1;
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_jal();
        test_sw();
        test_back_to_back();
        test_stall();
        test_flush();
        test_rst_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
